// File: rtl/car_collision_checker.sv
// car_collision_checker: on a frame tick, snapshots the frog and the 7 car
// entries, then scans one car per cycle. It reports hit/no-hit with a 1-cycle
// done pulse and the lane of the first colliding car. The lowest index wins.
// Optional feature macro: COLLISION_GRACE_EN suppresses reported hits for
// GRACE_FRAMES scans after reset or respawn.
module car_collision_checker #(
  parameter logic [9:0] BLOCKSIZE     = 10'd32,
  parameter logic [9:0] X_OFFSET_LEFT = 10'd96,
  parameter logic [9:0] LANE0_Y       = 10'd64,
  parameter logic [7:0] GRACE_FRAMES  = 8'd60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       respawn,
  input  logic [9:0] frog_x,
  input  logic [9:0] frog_y,
  input  logic [9:0] lane0_car0_x,
  input  logic [9:0] lane1_car0_x,
  input  logic [9:0] lane2_car0_x,
  input  logic [9:0] lane3_car0_x,
  input  logic [9:0] lane4_car0_x,
  input  logic [9:0] lane4_car1_x,
  input  logic [9:0] lane5_car0_x,
  input  logic [9:0] lane0_length,
  input  logic [9:0] lane1_length,
  input  logic [9:0] lane2_length,
  input  logic [9:0] lane3_length,
  input  logic [9:0] lane4_length,
  input  logic [9:0] lane5_length,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [2:0] hit_lane
);

  localparam int unsigned CW = 10;  // coordinate width
  localparam int unsigned AW = 11;  // overflow-free evaluation width
  localparam int unsigned NCARS = 7;
  localparam int unsigned NLANES = 6;
  localparam logic [2:0] LAST_IDX = 3'd6;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [CW-1:0]   frog_x_q;
  logic [CW-1:0]   frog_y_q;
  logic [CW-1:0]   car_x_q [NCARS];
  logic [CW-1:0]   len_q   [NLANES];

  logic [CW-1:0]   cur_x;
  logic [CW-1:0]   cur_len;
  logic [2:0]      cur_lane;
  logic [AW-1:0]   eff_l;
  logic [AW-1:0]   car_r;
  logic [AW-1:0]   lane_y;
  logic [AW-1:0]   lane_b;
  logic [AW-1:0]   frog_r;
  logic [AW-1:0]   frog_b;
  logic            hx;
  logic            hy;
  logic            entry_hit;
  logic            report_now;
  logic            grace_active;

  // Select the car-table entry addressed by idx (index -> lane mapping)
  always_comb begin
    cur_x    = '0;
    cur_len  = '0;
    cur_lane = 3'd0;
    case (idx)
      3'd0: begin cur_x = car_x_q[0]; cur_len = len_q[0]; cur_lane = 3'd0; end
      3'd1: begin cur_x = car_x_q[1]; cur_len = len_q[1]; cur_lane = 3'd1; end
      3'd2: begin cur_x = car_x_q[2]; cur_len = len_q[2]; cur_lane = 3'd2; end
      3'd3: begin cur_x = car_x_q[3]; cur_len = len_q[3]; cur_lane = 3'd3; end
      3'd4: begin cur_x = car_x_q[4]; cur_len = len_q[4]; cur_lane = 3'd4; end
      3'd5: begin cur_x = car_x_q[5]; cur_len = len_q[4]; cur_lane = 3'd4; end
      3'd6: begin cur_x = car_x_q[6]; cur_len = len_q[5]; cur_lane = 3'd5; end
      default: ;
    endcase
  end

  // Half-open overlap test of frog square vs. visible part of the current car
  always_comb begin
    eff_l  = (cur_x < X_OFFSET_LEFT) ? AW'(X_OFFSET_LEFT) : AW'(cur_x);
    car_r  = AW'(cur_x) + AW'(cur_len);
    lane_y = AW'(LANE0_Y) + AW'(AW'(cur_lane) * AW'(BLOCKSIZE));
    lane_b = lane_y + AW'(BLOCKSIZE);
    frog_r = AW'(frog_x_q) + AW'(BLOCKSIZE);
    frog_b = AW'(frog_y_q) + AW'(BLOCKSIZE);
    hx = (AW'(frog_x_q) < car_r) && (eff_l < frog_r) && (eff_l < car_r);
    hy = (AW'(frog_y_q) < lane_b) && (lane_y < frog_b);
    entry_hit = hx && hy;
  end

  assign report_now = (state == SCAN) && (entry_hit || (idx == LAST_IDX));

`ifdef COLLISION_GRACE_EN
  logic [7:0] grace;

  assign grace_active = (grace != 8'd0);

  // Grace counter: reload on reset/respawn, count down once per report
  always_ff @(posedge clk) begin
    if (reset || respawn) begin
      grace <= GRACE_FRAMES;
    end else if (report_now && grace_active) begin
      grace <= grace - 8'd1;
    end
  end
`else
  logic unused_respawn;

  assign grace_active   = 1'b0;
  assign unused_respawn = respawn;
`endif

  // Scan FSM with registered outputs and input snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
      hit_lane <= 3'd0;
      frog_x_q <= '0;
      frog_y_q <= '0;
      for (int i = 0; i < int'(NCARS); i++) car_x_q[i] <= '0;
      for (int i = 0; i < int'(NLANES); i++) len_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            frog_x_q   <= frog_x;
            frog_y_q   <= frog_y;
            car_x_q[0] <= lane0_car0_x;
            car_x_q[1] <= lane1_car0_x;
            car_x_q[2] <= lane2_car0_x;
            car_x_q[3] <= lane3_car0_x;
            car_x_q[4] <= lane4_car0_x;
            car_x_q[5] <= lane4_car1_x;
            car_x_q[6] <= lane5_car0_x;
            len_q[0]   <= lane0_length;
            len_q[1]   <= lane1_length;
            len_q[2]   <= lane2_length;
            len_q[3]   <= lane3_length;
            len_q[4]   <= lane4_length;
            len_q[5]   <= lane5_length;
            idx        <= 3'd0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (report_now) begin
            state    <= REPORT;
            busy     <= 1'b0;
            done     <= 1'b1;
            hit      <= entry_hit && !grace_active;
            hit_lane <= (entry_hit && !grace_active) ? cur_lane : 3'd0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        REPORT: begin
          hit   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
